// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, registered result and C/V/Z flags, multi-cycle shifts.
// `define ALU_MUL_EN adds a W-cycle shift-add multiplier on opcode 10.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_z,
  output logic         illegal,
  output logic         busy
);
  localparam int SHW = $clog2(W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  logic           take, multi, mulop, last, ismul;
  logic [3:0]     opr;
  logic [W-1:0]   wk, wk_n;
  logic           shc;
  logic [SHW:0]   cnt;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   r1, mulr, mulh;
  logic           c1, v1, z1, il1;
  logic [W:0]     sum, dif;

  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state == IDLE) |
                     ((state == DONE) & out_ready);
  assign take      = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign last      = (cnt == (SHW+1)'(1));

`ifdef ALU_MUL_EN
  logic [2*W-1:0] prod, prod_n;
  logic [W:0]     psum;
  logic [W-1:0]   rhi;

  assign mulop = (op == 4'd10);
  assign ismul = (opr == 4'd10);
  // hi half accumulates, lo half shifts the multiplier out
  assign psum   = {1'b0, prod[2*W-1:W]} +
                  {1'b0, {W{prod[0]}} & wk};
  assign prod_n = {psum, prod[W-1:1]};
  assign mulr   = prod_n[W-1:0];
  assign mulh   = prod_n[2*W-1:W];
  assign result_hi = rhi;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
      rhi  <= '0;
    end else if (take) begin
      prod <= {{W{1'b0}}, b};
      if (!multi) rhi <= '0;
    end else if (state == BUSY) begin
      prod <= prod_n;
      if (last) rhi <= ismul ? mulh : '0;
    end
  end
`else
  assign mulop     = 1'b0;
  assign ismul     = 1'b0;
  assign mulr      = '0;
  assign mulh      = '0;
  assign result_hi = '0;
`endif

  assign multi = mulop |
                 ((op == 4'd6 || op == 4'd7 ||
                   op == 4'd8) && shamt != '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (take) state_n = multi ? BUSY : DONE;
      BUSY: if (last) state_n = DONE;
      DONE:
        if (out_ready)
          state_n = take ? (multi ? BUSY : DONE) : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    r1  = '0;
    c1  = flag_c;
    v1  = flag_v;
    il1 = 1'b0;
    sum = {1'b0, a} + {1'b0, b} +
          {{W{1'b0}}, (op == 4'd2) & flag_c};
    dif = {1'b0, a} - {1'b0, b};
    unique case (op)
      4'd0: r1 = a & b;
      4'd1, 4'd2: begin
        r1 = sum[W-1:0];
        c1 = sum[W];
        v1 = (a[W-1] == b[W-1]) &
             (sum[W-1] != a[W-1]);
      end
      4'd3: begin
        r1 = dif[W-1:0];
        c1 = dif[W];
        v1 = (a[W-1] != b[W-1]) &
             (dif[W-1] != a[W-1]);
      end
      4'd4: r1 = a ^ b;
      4'd5: r1 = b;
      4'd6, 4'd7, 4'd8: r1 = a;
      4'd9: r1 = (a > b) ? W'(1) : '0;
      4'd11: begin
        c1 = 1'b0;
        v1 = 1'b0;
      end
      default: il1 = 1'b1;
    endcase
    if (il1)             z1 = flag_z;
    else if (op == 4'd11) z1 = 1'b0;
    else                 z1 = (r1 == '0);
  end

  always_comb begin
    wk_n = wk;
    shc  = 1'b0;
    unique case (opr)
      4'd6:    {shc, wk_n} = {wk, 1'b0};
      4'd7:    {wk_n, shc} = {1'b0, wk};
      default: {wk_n, shc} = {wk[W-1], wk};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opr     <= '0;
      wk      <= '0;
      cnt     <= '0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_z  <= 1'b0;
      illegal <= 1'b0;
    end else if (take) begin
      opr <= op;
      wk  <= a;
      cnt <= mulop ? (SHW+1)'(W) : {1'b0, shamt};
      if (!multi) begin
        result  <= r1;
        flag_c  <= c1;
        flag_v  <= v1;
        flag_z  <= z1;
        illegal <= il1;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (!ismul) wk <= wk_n;
      if (last) begin
        illegal <= 1'b0;
        if (ismul) begin
          result <= mulr;
          flag_c <= |mulh;
          flag_v <= 1'b0;
          flag_z <= (mulr == '0);
        end else begin
          result <= wk_n;
          flag_c <= shc;
          flag_z <= (wk_n == '0);
        end
      end
    end
  end
endmodule
